// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the FIR MAC sequencer slice.
//   fir_state_e      : sequencer FSM states (IDLE, MAC, HOLD)
//   DEFAULT_*        : default sample/coefficient widths and tap count
//   calc_aw()        : tap index width for a given tap count
//   calc_acc_width() : accumulator width wide enough that a full sum of
//                      N_TAPS full-precision products can never overflow
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } fir_state_e;

  localparam int DEFAULT_DATA_WIDTH  = 17;
  localparam int DEFAULT_COEFF_WIDTH = 17;
  localparam int DEFAULT_N_TAPS      = 16;

  function automatic int calc_aw(input int n_taps);
    return $clog2(n_taps);
  endfunction

  // One guard bit per doubling of the tap count absorbs the growth of the sum.
  function automatic int calc_acc_width(input int data_width, input int coeff_width,
                                        input int n_taps);
    return data_width + coeff_width + calc_aw(n_taps);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit
// Purely combinational multiply-accumulate step: acc_o = acc_i + sample_i * coef_i.
// The product is kept at full signed precision and sign-extended into the
// accumulator; no rounding or saturation.
//   sample_i : signed sample, DATA_WIDTH bits
//   coef_i   : signed coefficient, COEFF_WIDTH bits
//   acc_i    : running sum, ACC_WIDTH bits
//   acc_o    : running sum plus this product, ACC_WIDTH bits
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COEFF_WIDTH = DEFAULT_COEFF_WIDTH,
  parameter int ACC_WIDTH   = calc_acc_width(DEFAULT_DATA_WIDTH, DEFAULT_COEFF_WIDTH,
                                             DEFAULT_N_TAPS)
) (
  input  logic signed [DATA_WIDTH-1:0]  sample_i,
  input  logic signed [COEFF_WIDTH-1:0] coef_i,
  input  logic signed [ACC_WIDTH-1:0]   acc_i,
  output logic signed [ACC_WIDTH-1:0]   acc_o
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;

  logic signed [PROD_WIDTH-1:0] product;

  // Widen both operands first so the multiply is evaluated at full product width.
  assign product = PROD_WIDTH'(sample_i) * PROD_WIDTH'(coef_i);
  assign acc_o   = acc_i + ACC_WIDTH'(product);

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Time-multiplexed FIR filter: one shared multiplier, one tap per cycle.
// Each accepted sample is written into a circular history ring, then N_TAPS
// MAC cycles compute y = sum coef[k] * x[n-k]; the result is held until the
// consumer takes it.
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid_i      : sample offered
//   in_ready_o      : sequencer idle, sample taken when in_valid_i && in_ready_o
//   in_data_i       : signed sample
//   coef_we_i       : coefficient write strobe (honoured only while idle)
//   coef_addr_i     : coefficient index
//   coef_wdata_i    : signed coefficient value
//   out_valid_o     : result available
//   out_ready_i     : result consumed when out_valid_o && out_ready_i
//   out_data_o      : signed filter result
//   busy_o          : pass in progress or result waiting
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter  int COEFF_WIDTH = DEFAULT_COEFF_WIDTH,
  parameter  int N_TAPS      = DEFAULT_N_TAPS,
  localparam int AW          = calc_aw(N_TAPS),
  localparam int ACC_WIDTH   = calc_acc_width(DATA_WIDTH, COEFF_WIDTH, N_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic signed [DATA_WIDTH-1:0]  in_data_i,
  input  logic                          coef_we_i,
  input  logic        [AW-1:0]          coef_addr_i,
  input  logic signed [COEFF_WIDTH-1:0] coef_wdata_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic signed [ACC_WIDTH-1:0]   out_data_o,
  output logic                          busy_o
);

  fir_state_e                   state_q;
  logic        [AW-1:0]         wr_ptr_q;
  logic        [AW-1:0]         k_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic signed [ACC_WIDTH-1:0]  out_data_q;
  logic                         out_valid_q;
  logic signed [DATA_WIDTH-1:0] ring_q [N_TAPS];
  logic signed [COEFF_WIDTH-1:0] coef_q [N_TAPS];

  logic [AW-1:0] rd_idx;
  logic          in_accept;
  logic          out_accept;
  logic          last_tap;

  // The newest sample sits at wr_ptr_q; k taps back is wr_ptr_q - k, and the
  // AW-bit subtraction wraps naturally because N_TAPS is a power of two.
  assign rd_idx     = wr_ptr_q - k_q;
  assign in_accept  = (state_q == IDLE) && in_valid_i;
  assign out_accept = out_valid_q && out_ready_i;
  assign last_tap   = (k_q == AW'(N_TAPS - 1));

  fir_mac_unit #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_mac (
    .sample_i (ring_q[rd_idx]),
    .coef_i   (coef_q[k_q]),
    .acc_i    (acc_q),
    .acc_o    (acc_d)
  );

  // Ready and busy decode the registered state only, so neither depends
  // combinationally on in_valid_i or out_ready_i.
  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < N_TAPS; i++) begin
        ring_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          // A coefficient write on the accept edge lands before the first MAC
          // cycle reads the table, so the new pass already sees it.
          if (coef_we_i) begin
            coef_q[coef_addr_i] <= coef_wdata_i;
          end
          if (in_accept) begin
            ring_q[wr_ptr_q] <= in_data_i;
            acc_q            <= '0;
            k_q              <= '0;
            state_q          <= MAC;
          end
        end

        MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + AW'(1);
          // The final sum is captured straight from the MAC unit so the
          // result is valid on the same edge that enters HOLD.
          if (last_tap) begin
            out_data_q  <= acc_d;
            out_valid_q <= 1'b1;
            wr_ptr_q    <= wr_ptr_q + AW'(1);
            state_q     <= HOLD;
          end
        end

        HOLD: begin
          if (out_accept) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 17: signed sample width.
REQ-002 Parameter COEFF_WIDTH, default 17: signed coefficient width.
REQ-003 Parameter N_TAPS, default 16: tap count; SHALL be a power of two, >= 2.
REQ-004 Derived constants SHALL be fixed as follows: AW = clog2(N_TAPS); ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + AW.
REQ-005 clk  input  1  clock; all state changes occur on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  sample offered.
REQ-008 in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-009 in_data  input  DATA_WIDTH  signed sample.
REQ-010 coef_we  input  1  coefficient write strobe.
REQ-011 coef_addr  input  AW  coefficient index.
REQ-012 coef_wdata  input  COEFF_WIDTH  signed coefficient value.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-015 out_data  output  ACC_WIDTH  signed filter result.
REQ-016 busy  output  1  high in MAC or HOLD.

Function
REQ-017 The block SHALL compute y = sum over k = 0..N_TAPS-1 of coef[k]*x[n-k], using one shared multiplier and one tap per cycle.
REQ-018 The FSM SHALL have states IDLE, MAC and HOLD; IDLE->MAC on input accept; MAC->HOLD after the tap with k = N_TAPS-1; HOLD->IDLE on output accept.
REQ-019 in_ready SHALL equal (state == IDLE) and SHALL be registered-state-derived only, with no combinational path from in_valid or out_ready.
REQ-020 On input accept, the block SHALL write in_data into the sample ring at wr_ptr, clear the accumulator, and set k = 0.
REQ-021 On each MAC edge, the block SHALL update acc += coef[k] * ring[(wr_ptr - k) mod N_TAPS] and set k = k + 1.
REQ-022 wr_ptr SHALL increment modulo N_TAPS, wrapping N_TAPS-1 -> 0, on the edge leaving MAC.
REQ-023 Latency: for an input accepted at edge t, out_valid SHALL go high after edge t+N_TAPS, with out_data valid in the same cycle.
REQ-024 In HOLD, out_valid SHALL stay 1 and out_data SHALL hold stable until out_ready is high; on accept, out_valid SHALL drop on the next edge.
REQ-025 Throughput SHALL be at most one sample per N_TAPS+2 cycles.
REQ-026 Products SHALL be full-precision signed (DATA_WIDTH+COEFF_WIDTH bits) and sign-extended into the accumulator; no saturation or rounding SHALL be applied, and overflow cannot occur.
REQ-027 A coefficient write SHALL take effect only in IDLE, with coef[coef_addr] <= coef_wdata on that edge.
REQ-028 A coefficient write in MAC or HOLD SHALL be ignored with no side effect.
REQ-029 When coef_we and an input accept occur on the same IDLE edge, both SHALL take effect, and the ensuing MAC pass SHALL use the new coefficient.
REQ-030 The sample ring SHALL retain history across passes; it is cleared only by reset.

Reset
REQ-031 Asynchronous assertion SHALL force state=IDLE, wr_ptr=0, k=0, acc=0, out_valid=0, out_data=0, every ring entry=0 and every coef entry=0.
REQ-032 After reset, in_ready SHALL be 1 and busy SHALL be 0.
REQ-033 Reset during MAC or HOLD SHALL abort the pass and discard any partial result; no out_valid pulse SHALL follow.

Structure
REQ-034 Package fir_pkg SHALL hold the FSM state enum, default widths and the ACC_WIDTH/AW derivation functions.
REQ-035 One sub-module, fir_mac_unit, SHALL contain the combinational signed multiply plus accumulator add; the sequencer SHALL own all registers.

Verification
REQ-036 Impulse: coef[k]=k+1; feed 1 then 16 zeros, draining each result -> out_data 1,2,...,16 then 0.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_data stable, in_ready=0, busy=1; then out_ready=1 -> IDLE next edge.
REQ-038 Coefficient lockout: write coef[0]=100 during MAC -> ignored; same-edge IDLE write with input accept -> new value used.
REQ-039 Extremes: all coefficients and samples -65536, 16 samples -> final out_data = 2^36, no overflow.
REQ-040 Reset mid-MAC at k=7 -> outputs at reset values, no out_valid; the next impulse response matches REQ-036 exactly.
REQ-041 Ring wrap: 40 random samples against a reference model -> every output matches and wr_ptr wraps correctly.
